// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: drives the UART byte receiver and assembles HDR,CMD,LEN,PAYLOAD[LEN][,CHK] frames.
// Build option UART_RX_FRAME_CHKSUM_EN: when defined, a trailing CHK byte is expected and verified.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] HDR_BYTE     = 8'h55,
  parameter int         MAX_LEN      = 16,
  parameter int         ADDR_W       = 4,
  parameter int         TIMEOUT_CLKS = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I_enable,
  input  logic              I_rx_done,
  input  logic [7:0]        I_rx_data,
  output logic              O_rx_start,
  output logic              O_wr_en,
  output logic [ADDR_W-1:0] O_wr_addr,
  output logic [7:0]        O_wr_data,
  output logic [7:0]        O_cmd,
  output logic [7:0]        O_len,
  output logic              O_frame_valid,
  output logic              O_frame_err,
  output logic [1:0]        O_err_code
);

  localparam int               TMO_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HEAD = 3'd1;
  localparam logic [2:0] ST_CMD  = 3'd2;
  localparam logic [2:0] ST_LEN  = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;
`ifdef UART_RX_FRAME_CHKSUM_EN
  localparam logic [2:0] ST_CHK  = 3'd5;
`endif
  localparam logic [2:0] ST_DONE = 3'd6;
  localparam logic [2:0] ST_ERR  = 3'd7;

  // State entered once the last payload byte (or a zero LEN) has been taken.
`ifdef UART_RX_FRAME_CHKSUM_EN
  localparam logic [2:0] ST_TAIL = ST_CHK;
`else
  localparam logic [2:0] ST_TAIL = ST_DONE;
`endif

  logic              s0_reg, s1_reg, s2_reg;
  logic              rx_stb;
  logic [2:0]        state_reg, state_next;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [7:0]        cmd_reg, cmd_next;
  logic [7:0]        len_reg, len_next;
  logic [7:0]        cmd_out_reg, cmd_out_next;
  logic [7:0]        len_out_reg, len_out_next;
  logic [1:0]        err_code_reg, err_code_next;
  logic              counting;
`ifdef UART_RX_FRAME_CHKSUM_EN
  logic [7:0]        sum_reg, sum_next;
`endif

  assign rx_stb = s1_reg & ~s2_reg;

`ifdef UART_RX_FRAME_CHKSUM_EN
  assign counting = (state_reg == ST_CMD) || (state_reg == ST_LEN) ||
                    (state_reg == ST_DATA) || (state_reg == ST_CHK);
`else
  assign counting = (state_reg == ST_CMD) || (state_reg == ST_LEN) ||
                    (state_reg == ST_DATA);
`endif

  always_comb begin
    state_next    = state_reg;
    tmo_next      = tmo_reg;
    idx_next      = idx_reg;
    cmd_next      = cmd_reg;
    len_next      = len_reg;
    cmd_out_next  = cmd_out_reg;
    len_out_next  = len_out_reg;
    err_code_next = err_code_reg;
`ifdef UART_RX_FRAME_CHKSUM_EN
    sum_next      = sum_reg;
`endif
    if (!I_enable) begin
      state_next = ST_IDLE;
      tmo_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_HEAD;
        ST_HEAD: begin
          if (rx_stb && (I_rx_data == HDR_BYTE)) begin
            state_next = ST_CMD;
            tmo_next   = '0;
`ifdef UART_RX_FRAME_CHKSUM_EN
            sum_next   = 8'h00;
`endif
          end
        end
        ST_CMD: begin
          if (rx_stb) begin
            cmd_next   = I_rx_data;
            tmo_next   = '0;
            state_next = ST_LEN;
`ifdef UART_RX_FRAME_CHKSUM_EN
            sum_next   = I_rx_data;
`endif
          end
        end
        ST_LEN: begin
          if (rx_stb) begin
            tmo_next = '0;
            if (I_rx_data > MAX_LEN_B) begin
              state_next    = ST_ERR;
              err_code_next = 2'd2;
            end else begin
              len_next   = I_rx_data;
              idx_next   = '0;
              state_next = (I_rx_data != 8'h00) ? ST_DATA : ST_TAIL;
`ifdef UART_RX_FRAME_CHKSUM_EN
              sum_next   = sum_reg + I_rx_data;
`endif
            end
          end
        end
        ST_DATA: begin
          if (rx_stb) begin
            tmo_next = '0;
            idx_next = idx_reg + ADDR_W'(1);
`ifdef UART_RX_FRAME_CHKSUM_EN
            sum_next = sum_reg + I_rx_data;
`endif
            if (8'(idx_reg) == (len_reg - 8'd1)) state_next = ST_TAIL;
          end
        end
`ifdef UART_RX_FRAME_CHKSUM_EN
        ST_CHK: begin
          if (rx_stb) begin
            tmo_next = '0;
            if (I_rx_data == sum_reg) begin
              state_next = ST_DONE;
            end else begin
              state_next    = ST_ERR;
              err_code_next = 2'd3;
            end
          end
        end
`endif
        ST_DONE: begin
          cmd_out_next = cmd_reg;
          len_out_next = len_reg;
          state_next   = ST_HEAD;
        end
        ST_ERR:  state_next = ST_HEAD;
        default: state_next = ST_IDLE;
      endcase
      // A byte landing on the final timeout cycle takes priority and restarts the count.
      if (counting && !rx_stb) begin
        if (tmo_reg == TMO_LAST) begin
          state_next    = ST_ERR;
          err_code_next = 2'd1;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_reg       <= 1'b0;
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      state_reg    <= ST_IDLE;
      tmo_reg      <= '0;
      idx_reg      <= '0;
      cmd_reg      <= 8'h00;
      len_reg      <= 8'h00;
      cmd_out_reg  <= 8'h00;
      len_out_reg  <= 8'h00;
      err_code_reg <= 2'd0;
`ifdef UART_RX_FRAME_CHKSUM_EN
      sum_reg      <= 8'h00;
`endif
    end else begin
      s0_reg       <= I_rx_done;
      s1_reg       <= s0_reg;
      s2_reg       <= s1_reg;
      state_reg    <= state_next;
      tmo_reg      <= tmo_next;
      idx_reg      <= idx_next;
      cmd_reg      <= cmd_next;
      len_reg      <= len_next;
      cmd_out_reg  <= cmd_out_next;
      len_out_reg  <= len_out_next;
      err_code_reg <= err_code_next;
`ifdef UART_RX_FRAME_CHKSUM_EN
      sum_reg      <= sum_next;
`endif
    end
  end

  assign O_rx_start    = (state_reg != ST_IDLE);
  assign O_wr_en       = (state_reg == ST_DATA) && rx_stb && I_enable;
  assign O_wr_addr     = idx_reg;
  assign O_wr_data     = O_wr_en ? I_rx_data : 8'h00;
  assign O_cmd         = cmd_out_reg;
  assign O_len         = len_out_reg;
  assign O_frame_valid = (state_reg == ST_DONE);
  assign O_frame_err   = (state_reg == ST_ERR);
  assign O_err_code    = err_code_reg;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: random and directed byte streams checked against a frame-level model.
// Honours UART_RX_FRAME_CHKSUM_EN the same way as the design.
module tb_uart_rx_frame_ctrl;
  localparam int         T    = 64;
  localparam int         MAXL = 16;
  localparam int         AW   = 4;
  localparam logic [7:0] HDR  = 8'h55;
`ifdef UART_RX_FRAME_CHKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          I_enable = 1'b0;
  logic          I_rx_done = 1'b0;
  logic [7:0]    I_rx_data = 8'h00;
  logic          O_rx_start, O_wr_en, O_frame_valid, O_frame_err;
  logic [AW-1:0] O_wr_addr;
  logic [7:0]    O_wr_data, O_cmd, O_len;
  logic [1:0]    O_err_code;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .HDR_BYTE(HDR), .MAX_LEN(MAXL), .ADDR_W(AW), .TIMEOUT_CLKS(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .I_enable(I_enable), .I_rx_done(I_rx_done),
    .I_rx_data(I_rx_data), .O_rx_start(O_rx_start), .O_wr_en(O_wr_en),
    .O_wr_addr(O_wr_addr), .O_wr_data(O_wr_data), .O_cmd(O_cmd), .O_len(O_len),
    .O_frame_valid(O_frame_valid), .O_frame_err(O_frame_err), .O_err_code(O_err_code)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, obs);
    end
  endtask

  // Observed activity, sampled mid-cycle.
  logic [11:0] obs_wr[$];
  int          valid_cnt = 0;
  int          err_cnt = 0;
  always @(negedge clk) begin
    if (O_wr_en) obs_wr.push_back({O_wr_addr, O_wr_data});
    if (O_frame_valid) valid_cnt++;
    if (O_frame_err) err_cnt++;
  end

  // Frame-level reference model.
  bit          in_frame = 1'b0;
  byte_q_t     cur;
  logic [11:0] exp_wr[$];
  int          exp_valid = 0;
  int          exp_err = 0;
  logic [7:0]  exp_cmd = 8'h00;
  logic [7:0]  exp_len = 8'h00;
  logic [1:0]  exp_code = 2'd0;

  task automatic model_byte(input logic [7:0] b);
    int need;
    logic [7:0] s;
    if (!in_frame) begin
      if (b == HDR) begin
        in_frame = 1'b1;
        cur.delete();
      end
      return;
    end
    cur.push_back(b);
    if (cur.size() == 2 && int'(b) > MAXL) begin
      exp_err++;
      exp_code = 2'd2;
      in_frame = 1'b0;
      return;
    end
    if (cur.size() >= 3 && cur.size() <= 2 + int'(cur[1]))
      exp_wr.push_back({4'(cur.size() - 3), b});
    need = 2 + int'(cur[1]) + CHK_BYTES;
    if (cur.size() == need) begin
      in_frame = 1'b0;
      s = 8'h00;
      for (int i = 0; i < 2 + int'(cur[1]); i++) s = s + cur[i];
      if (CHK_BYTES == 1 && b != s) begin
        exp_err++;
        exp_code = 2'd3;
      end else begin
        exp_valid++;
        exp_cmd = cur[0];
        exp_len = cur[1];
      end
    end
  endtask

  task automatic check_window();
    check("wr_cnt", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
      check("wr_addr_data", obs_wr[i], exp_wr[i]);
    obs_wr.delete();
    exp_wr.delete();
    check("valid_cnt", valid_cnt, exp_valid);
    check("err_cnt", err_cnt, exp_err);
    check("cmd", O_cmd, exp_cmd);
    check("len", O_len, exp_len);
    check("err_code", O_err_code, exp_code);
  endtask

  // Called on a falling edge; the next byte's done rises exactly gap cycles later.
  task automatic send_byte(input logic [7:0] b, input int gap);
    I_rx_data = b;
    I_rx_done = 1'b1;
    repeat (4) @(negedge clk);
    I_rx_done = 1'b0;
    repeat (gap - 4) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] b, input int gap);
    model_byte(b);
    if (in_frame && gap > T) begin
      exp_err++;
      exp_code = 2'd1;
      in_frame = 1'b0;
    end
    send_byte(b, gap);
    check_window();
  endtask

  task automatic send_frame(input logic [7:0] cmd, input byte_q_t pl, input bit bad_chk,
                            input int tmo_at, input int bnd_at);
    byte_q_t f;
    logic [7:0] s;
    int gap;
    f.push_back(HDR);
    f.push_back(cmd);
    f.push_back(8'(pl.size()));
    s = cmd + 8'(pl.size());
    foreach (pl[i]) begin
      f.push_back(pl[i]);
      s = s + pl[i];
    end
    if (CHK_BYTES == 1) f.push_back(bad_chk ? s + 8'd1 : s);
    foreach (f[i]) begin
      gap = int'($urandom_range(8, 20));
      if (i == tmo_at) gap = T + 6;
      else if (i == bnd_at) gap = T;
      xfer(f[i], gap);
    end
  endtask

  task automatic drop_enable();
    I_enable = 1'b0;
    @(negedge clk);
    check("rx_start_off", O_rx_start, 1'b0);
    in_frame = 1'b0;
    repeat (8) @(negedge clk);
    check_window();
    I_enable = 1'b1;
    repeat (2) @(negedge clk);
    check("rx_start_on", O_rx_start, 1'b1);
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_start", O_rx_start, 1'b0);
    check("rst_wr_en", O_wr_en, 1'b0);
    check("rst_wr_addr", O_wr_addr, 0);
    check("rst_wr_data", O_wr_data, 8'h00);
    check("rst_cmd", O_cmd, 8'h00);
    check("rst_len", O_len, 8'h00);
    check("rst_valid", O_frame_valid, 1'b0);
    check("rst_err", O_frame_err, 1'b0);
    check("rst_err_code", O_err_code, 2'd0);
  endtask

  initial begin
    byte_q_t pl;
    int n, len, tmo_at, bnd_at;
    bit bad;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    I_enable = 1'b1;
    repeat (2) @(negedge clk);
    check("rx_start_after_enable", O_rx_start, 1'b1);

    pl = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(8'h01, pl, 1'b0, -1, -1);
    pl.delete();
    send_frame(8'h02, pl, 1'b0, -1, -1);
    xfer(HDR, 10); xfer(8'h01, 10); xfer(8'h11, 10);
    pl = '{8'h3C, 8'hC3};
    send_frame(8'h07, pl, 1'b0, -1, -1);
    pl = '{8'h10};
`ifdef UART_RX_FRAME_CHKSUM_EN
    send_frame(8'h01, pl, 1'b1, -1, -1);
`else
    send_frame(8'h01, pl, 1'b0, -1, -1);
`endif
    xfer(HDR, 10); xfer(8'h01, T + 6);
    pl = '{8'h5A, 8'hA5};
    send_frame(8'h21, pl, 1'b0, -1, 1);
    send_frame(8'h22, pl, 1'b0, -1, 3);

    xfer(HDR, 10); xfer(8'h03, 10); xfer(8'h05, 10); xfer(8'h11, 10); xfer(8'h22, 10);
    drop_enable();
    pl = '{8'h01, 8'h02, 8'h03};
    send_frame(8'h09, pl, 1'b0, -1, -1);

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) xfer(8'(HDR + 8'($urandom_range(1, 254))), 9);
      len = int'($urandom_range(0, MAXL + 2));
      if (len > MAXL) begin
        xfer(HDR, 9); xfer(8'($urandom), 9); xfer(8'(len), 9);
        continue;
      end
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      n = 3 + len + CHK_BYTES;
      bad = (CHK_BYTES == 1) && ($urandom_range(0, 4) == 0);
      tmo_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      bnd_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      send_frame(8'($urandom), pl, bad, tmo_at, bnd_at);
    end

    xfer(HDR, 10); xfer(8'h01, 10); xfer(8'h04, 10); xfer(8'hA0, 10);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs();
    in_frame = 1'b0;
    exp_cmd = 8'h00;
    exp_len = 8'h00;
    exp_code = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_window();
    pl = '{8'hDE, 8'hAD};
    send_frame(8'h33, pl, 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
